fetch_stage: RTL and testbench
==============================

# fetch_stage

Front end of the five-stage pipeline. It owns the program counter, drives the instruction memory address, and queues fetched {pc, inst} pairs in a 2-entry buffer. Decode drains the buffer through a valid/ready handshake. Execute redirects fetch on taken branches and jumps; a redirect flushes every queued instruction.

## Interface
- RESET_PC, 32'h0100_0000, PC value loaded on reset.
- DEPTH, 2, buffer entries. Must be a power of two and at least 2.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  execute reports a taken branch or jump this cycle.
- redirect_pc  in  32  target PC. Bits [1:0] are ignored and treated as 0.
- imem_addr  out  32  instruction memory address, equal to fetch_pc.
- imem_data  in  32  instruction word. Combinational read of imem_addr, valid in the same cycle.
- f_valid  out  1  the buffer head holds a valid instruction.
- f_pc  out  32  PC of the buffer head.
- f_inst  out  32  instruction at the buffer head.
- d_ready  in  1  decode accepts the head this cycle. Driven 0 by the hazard or stall logic.

## Operation
- State:
  - fetch_pc (32 bits).
  - Buffer: DEPTH entries of {pc, inst}, with rd_ptr, wr_ptr and count (0..DEPTH).
- pop = f_valid && d_ready.
- push = !redirect_valid && (count < DEPTH || pop).
  - Fetch pauses when the buffer is full and no pop occurs.
- Normal cycle:
  - On push: write {fetch_pc, imem_data} at wr_ptr, then fetch_pc <= fetch_pc + 4.
  - On pop: advance rd_ptr.
  - count changes by push − pop.
  - Push and pop in the same cycle while full is legal; count stays at DEPTH.
- Redirect (highest priority, overrides push and pop):
  - count <= 0, rd_ptr <= 0, wr_ptr <= 0.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - imem_data is discarded that cycle.
  - A pop asserted in the same cycle still counts as accepted by decode. The pipeline's flush logic handles the wrong-path squash.
- Outputs:
  - count > 0: f_valid = 1; f_pc and f_inst come from the entry at rd_ptr.
  - count == 0: f_valid = 0, f_pc = 0, f_inst = 32'h0000_0013 (NOP).
- Arithmetic:
  - PC increment is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
  - Pointers wrap modulo DEPTH.
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - fetch_pc = RESET_PC, pointers = 0, count = 0.
  - Outputs read f_valid = 0, f_pc = 0, f_inst = NOP, imem_addr = RESET_PC.
  - Buffer contents are don't-care.

## Timing
- Fetch-to-decode latency is 1 cycle: the instruction fetched at edge N appears on f_* after edge N.
- First cycle after reset deassertion: the RESET_PC fetch is pushed. f_valid = 1 with f_pc = RESET_PC from the following cycle.
- Redirect sampled at edge N:
  - The target is fetched in cycle N+1.
  - f_valid = 1 with f_pc = target after edge N+1.
  - f_valid = 0 for exactly the one cycle between them.
- Continuous d_ready = 1: one instruction per cycle after the first fill, with no bubbles.
- d_ready = 0: the head holds stable (f_pc and f_inst unchanged) until accepted or flushed.
- With d_ready = 0 from reset: the buffer fills in DEPTH cycles, then fetch_pc freezes at RESET_PC + 4·DEPTH.
- All outputs are registered or derived only from registered state and imem_data. There is no combinational path from d_ready or redirect_* to f_*.

## Structure
- Shared pipeline package holds:
  - NOP_INST = 32'h0000_0013.
  - Default RESET_PC.
  - Typedef fetch_entry_t {pc[31:0], inst[31:0]}, reused by the IF/ID register and decode.
- One natural sub-module, fetch_buffer: a synchronous FIFO with push, pop, flush, count, head outputs, and asynchronous reset.
- fetch_stage keeps the PC register, the push/pop/redirect priority logic, and the empty-output muxing.

## Test plan
- Reset, then d_ready = 1 with an imem model returning addr ^ 32'hA5A5_0000 -> f_pc sequence 0x0100_0000, 0x0100_0004, 0x0100_0008 on consecutive cycles, with f_inst matching.
- Hold d_ready = 0 for 5 cycles after reset -> count saturates at 2, imem_addr stays at 0x0100_0008, and the head stays at 0x0100_0000. Release d_ready -> 0x0100_0000, 0x0100_0004, 0x0100_0008 in order with no gap or duplicate.
- Buffer full, then redirect_valid = 1 with redirect_pc = 0x0100_0103 and d_ready = 1 in the same cycle -> next cycle f_valid = 0 and imem_addr = 0x0100_0100. The cycle after: f_pc = 0x0100_0100.
- Redirect to 0xFFFF_FFF8 with d_ready = 1 -> f_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Assert reset asynchronously mid-cycle while the buffer is full -> f_valid drops to 0 and imem_addr = RESET_PC before the next edge. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the front end.
//   NOP_INST         : canonical no-op word (addi x0, x0, 0).
//   DEFAULT_RESET_PC : PC loaded when the core comes out of reset.
//   fetch_entry_t    : {pc, inst} pair carried from fetch into the IF/ID register.
//   pc_next()        : sequential PC step, wraps modulo 2^32.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0100_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Handshake/bus bundle around the fetch stage.
//   redirect_valid/redirect_pc : taken branch/jump from execute
//   imem_addr/imem_data        : combinational instruction memory port
//   f_valid/f_pc/f_inst        : buffer head presented to decode
//   d_ready                    : decode accepts the head this cycle
// master = fetch stage side, slave = surrounding pipeline/memory side.
interface fetch_stage_if;

  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_inst;
  logic        d_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_data, d_ready,
    output imem_addr, f_valid, f_pc, f_inst
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_data, d_ready,
    input  imem_addr, f_valid, f_pc, f_inst
  );

endinterface

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {pc, inst} pairs.
//   clk, rst     : clock, asynchronous active-high reset
//   push_i       : write wr_entry_i at the tail
//   pop_i        : drop the head (caller only pops when count_o > 0)
//   flush_i      : empty the FIFO, overrides push and pop
//   wr_entry_i   : entry to write
//   head_o       : entry at the read pointer (stale when count_o == 0)
//   count_o      : number of valid entries, 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap by natural overflow.
module fetch_buffer
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  fetch_entry_t                 wr_entry_i,
  output fetch_entry_t                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wr_entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Pipeline front end: owns the PC, drives instruction memory, and queues
// fetched {pc, inst} pairs for decode.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_stage_if.master (redirect, imem port, decode handshake)
// Parameters: RESET_PC (PC after reset), DEPTH (buffer entries, power of two >= 2).
// Redirect beats push/pop; f_* depend only on registered state, never on
// d_ready or redirect_* combinationally.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          push, pop, flush;
  logic [CW-1:0] count;
  fetch_entry_t  head, wr_entry;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  assign pop   = bus.f_valid && bus.d_ready;
  assign flush = bus.redirect_valid;
  // A pop frees a slot in the same cycle, so a full buffer keeps streaming.
  assign push  = !bus.redirect_valid && ((count < CW'(DEPTH)) || pop);

  assign wr_entry.pc   = fetch_pc_q;
  assign wr_entry.inst = bus.imem_data;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
    else if (push)          fetch_pc_d = pc_next(fetch_pc_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_pc_q <= RESET_PC;
    else     fetch_pc_q <= fetch_pc_d;
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .pop_i      (pop),
    .flush_i    (flush),
    .wr_entry_i (wr_entry),
    .head_o     (head),
    .count_o    (count)
  );

  assign bus.imem_addr = fetch_pc_q;
  assign bus.f_valid   = (count != '0);
  assign bus.f_pc      = bus.f_valid ? head.pc   : 32'h0;
  assign bus.f_inst    = bus.f_valid ? head.inst : NOP_INST;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RPC   = 32'h0100_0000;
  localparam int          DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_if fif();

  fetch_stage #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (fif)
  );

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign fif.imem_data = imem_f(fif.imem_addr);

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue of fetched PCs and the next fetch address.
  logic [31:0] mq[$];
  logic [31:0] mpc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc = RPC;
  endtask

  task automatic model_edge();
    bit pop, push;
    int sz;
    sz   = mq.size();
    pop  = (sz > 0) && fif.d_ready;
    push = !fif.redirect_valid && ((sz < DEPTH) || pop);
    if (fif.redirect_valid) begin
      mq.delete();
      mpc = {fif.redirect_pc[31:2], 2'b00};
    end else begin
      if (pop)  void'(mq.pop_front());
      if (push) begin
        mq.push_back(mpc);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic check_model(input string tag);
    bit v;
    v = mq.size() > 0;
    chk({tag, ".valid"}, {31'b0, fif.f_valid}, {31'b0, v});
    chk({tag, ".pc"},    fif.f_pc,      v ? mq[0] : 32'h0);
    chk({tag, ".inst"},  fif.f_inst,    v ? imem_f(mq[0]) : NOP_INST);
    chk({tag, ".addr"},  fif.imem_addr, mpc);
  endtask

  // One clock: model consumes the inputs held before the edge, then compare #1 after.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic drive(input logic dr, input logic rv, input logic [31:0] rp);
    fif.d_ready        = dr;
    fif.redirect_valid = rv;
    fif.redirect_pc    = rp;
  endtask

  task automatic chk_exp(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] addr);
    chk({tag, ".valid"}, {31'b0, fif.f_valid}, {31'b0, v});
    chk({tag, ".pc"},    fif.f_pc,      v ? pc : 32'h0);
    chk({tag, ".inst"},  fif.f_inst,    v ? imem_f(pc) : NOP_INST);
    chk({tag, ".addr"},  fif.imem_addr, addr);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk_exp("reset", 1'b0, 32'h0, RPC);
    #2;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        dr;
    logic        rv;
    logic [31:0] rp;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0100_0000, 32'h0100_0004};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0100_0004, 32'h0100_0008};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0100_0008, 32'h0100_000C};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0100_0008, 32'h0100_0010};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0100_0008, 32'h0100_0010};
    tbl[5]  = '{1'b1, 1'b1, 32'h0100_0103, 1'b0, 32'h0,         32'h0100_0100};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0100_0100, 32'h0100_0104};
    tbl[7]  = '{1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0,         32'hFFFF_FFF8};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0000_0000};
    tbl[10] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 32'h0000_0004};

    drive(1'b0, 1'b0, 32'h0);
    model_reset();
    #12;
    chk_exp("por", 1'b0, 32'h0, RPC);
    rst = 1'b0;

    // Table: streaming, fill while stalled, redirect on full buffer, wrap at 2^32.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].dr, tbl[i].rv, tbl[i].rp);
      step($sformatf("tbl%0d.model", i));
      chk_exp($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].eaddr);
    end

    // Stall five cycles from reset, then release.
    drive(1'b0, 1'b0, 32'h0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step($sformatf("stall%0d.model", i));
      chk_exp($sformatf("stall%0d", i), 1'b1, RPC, (i == 0) ? RPC + 32'd4 : RPC + 32'd8);
    end
    drive(1'b1, 1'b0, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step($sformatf("release%0d.model", i));
      chk_exp($sformatf("release%0d", i), 1'b1, RPC + 32'(4 * i), RPC + 32'(4 * i) + 32'd8);
    end

    // Asynchronous reset mid-cycle with a full buffer.
    drive(1'b0, 1'b0, 32'h0);
    step("fill0");
    step("fill1");
    step("fill2");
    do_reset();
    drive(1'b1, 1'b0, 32'h0);
    step("restart.model");
    chk_exp("restart", 1'b1, RPC, RPC + 32'd4);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rp);
      step($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
